// File: rtl/branch_predictor_bht_if.sv
// Predictor bus: decode-side lookup, execute-side update, clears and statistics.
interface branch_predictor_bht_if #(
    parameter int XLEN      = 32,
    parameter int STAT_BITS = 32
);
    logic [XLEN-1:0]      lookup_pc;
    logic                 predict_taken;
    logic                 predict_hit;
    logic [XLEN-1:0]      predict_target;
    logic                 update_valid;
    logic [XLEN-1:0]      update_pc;
    logic                 update_taken;
    logic [XLEN-1:0]      update_target;
    logic                 update_mispredict;
    logic                 table_clear;
    logic                 stats_clear;
    logic [STAT_BITS-1:0] branch_count;
    logic [STAT_BITS-1:0] mispredict_count;

    // Pipeline side: issues lookups and resolved-branch updates.
    modport master (
        output lookup_pc, update_valid, update_pc, update_taken, update_target,
               update_mispredict, table_clear, stats_clear,
        input  predict_taken, predict_hit, predict_target, branch_count, mispredict_count
    );

    // Predictor side.
    modport slave (
        input  lookup_pc, update_valid, update_pc, update_taken, update_target,
               update_mispredict, table_clear, stats_clear,
        output predict_taken, predict_hit, predict_target, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor_bht.sv
// Direct-mapped saturating-counter branch history table with a tagged target
// buffer and saturating branch/mispredict statistics.
module branch_predictor_bht #(
    parameter int XLEN      = 32,
    parameter int ENTRIES   = 64,
    parameter int CTR_BITS  = 2,
    parameter int INDEX_LSB = 2,
    parameter int TAG_BITS  = 8,
    parameter int STAT_BITS = 32
) (
    input logic Clock,
    input logic nReset,
    branch_predictor_bht_if.slave bus
);
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int TAG_LSB = INDEX_LSB + IDX_W;
    // Weakly-not-taken: all ones below the MSB (just 0 for a 1-bit counter).
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    logic [CTR_BITS-1:0]  ctr_mem    [ENTRIES];
    logic [TAG_BITS-1:0]  tag_mem    [ENTRIES];
    logic [XLEN-1:0]      target_mem [ENTRIES];
    logic [ENTRIES-1:0]   valid_mem;
    logic [STAT_BITS-1:0] branch_cnt;
    logic [STAT_BITS-1:0] mispredict_cnt;

    logic [IDX_W-1:0]    lookup_idx;
    logic [TAG_BITS-1:0] lookup_tag;
    logic [IDX_W-1:0]    update_idx;
    logic [TAG_BITS-1:0] update_tag;
    logic                lookup_hit;
    logic                unused_pc_bits;

    // Two-way saturating step of a prediction counter.
    function automatic logic [CTR_BITS-1:0] ctr_step(input logic [CTR_BITS-1:0] c,
                                                     input logic taken);
        if (taken)
            return (c == '1) ? c : c + 1'b1;
        else
            return (c == '0) ? c : c - 1'b1;
    endfunction

    // Saturating increment of a statistics counter; no wrap past all-ones.
    function automatic logic [STAT_BITS-1:0] stat_inc(input logic [STAT_BITS-1:0] s,
                                                      input logic en);
        return (en && (s != '1)) ? s + 1'b1 : s;
    endfunction

    assign lookup_idx = bus.lookup_pc[INDEX_LSB +: IDX_W];
    assign lookup_tag = bus.lookup_pc[TAG_LSB +: TAG_BITS];
    assign update_idx = bus.update_pc[INDEX_LSB +: IDX_W];
    assign update_tag = bus.update_pc[TAG_LSB +: TAG_BITS];
    // PC bits outside the index/tag fields are deliberately ignored.
    assign unused_pc_bits = ^{bus.lookup_pc, bus.update_pc};

    // Lookup reads registered state only, so same-cycle updates are not bypassed.
    assign lookup_hit         = valid_mem[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
    assign bus.predict_taken  = ctr_mem[lookup_idx][CTR_BITS-1];
    assign bus.predict_hit    = lookup_hit;
    assign bus.predict_target = lookup_hit ? target_mem[lookup_idx] : '0;
    assign bus.branch_count     = branch_cnt;
    assign bus.mispredict_count = mispredict_cnt;

    // Table state: reset and table_clear restore the power-up contents; clear beats update.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset || bus.table_clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_mem[i]    <= CTR_INIT;
                tag_mem[i]    <= '0;
                target_mem[i] <= '0;
            end
            valid_mem <= '0;
        end else if (bus.update_valid) begin
            ctr_mem[update_idx] <= ctr_step(ctr_mem[update_idx], bus.update_taken);
            if (bus.update_taken) begin
                valid_mem[update_idx]  <= 1'b1;
                tag_mem[update_idx]    <= update_tag;
                target_mem[update_idx] <= bus.update_target;
            end
        end
    end

    // Statistics: stats_clear discards the update of the same cycle.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (bus.stats_clear) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (bus.update_valid) begin
            branch_cnt     <= stat_inc(branch_cnt, 1'b1);
            mispredict_cnt <= stat_inc(mispredict_cnt, bus.update_mispredict);
        end
    end
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht: default table with 4-bit statistics,
// plus a minimal 2-entry, 1-bit-counter instance.
module tb_branch_predictor_bht;
    logic Clock;
    logic nReset;
    int   checks;
    int   failures;

    branch_predictor_bht_if #(.XLEN(32), .STAT_BITS(4)) bus_a ();
    branch_predictor_bht_if #(.XLEN(32), .STAT_BITS(8)) bus_b ();

    branch_predictor_bht #(
        .XLEN(32), .ENTRIES(64), .CTR_BITS(2), .INDEX_LSB(2), .TAG_BITS(8), .STAT_BITS(4)
    ) dut_a (
        .Clock(Clock), .nReset(nReset), .bus(bus_a)
    );

    branch_predictor_bht #(
        .XLEN(32), .ENTRIES(2), .CTR_BITS(1), .INDEX_LSB(2), .TAG_BITS(8), .STAT_BITS(8)
    ) dut_b (
        .Clock(Clock), .nReset(nReset), .bus(bus_b)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic upd_a(input logic [31:0] pc, input logic taken,
                         input logic [31:0] tgt, input logic misp);
        bus_a.update_valid      = 1'b1;
        bus_a.update_pc         = pc;
        bus_a.update_taken      = taken;
        bus_a.update_target     = tgt;
        bus_a.update_mispredict = misp;
        tick();
        bus_a.update_valid      = 1'b0;
    endtask

    task automatic upd_b(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        bus_b.update_valid  = 1'b1;
        bus_b.update_pc     = pc;
        bus_b.update_taken  = taken;
        bus_b.update_target = tgt;
        tick();
        bus_b.update_valid  = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        nReset   = 1'b1;
        bus_a.lookup_pc = '0; bus_a.update_valid = 0; bus_a.update_pc = '0;
        bus_a.update_taken = 0; bus_a.update_target = '0; bus_a.update_mispredict = 0;
        bus_a.table_clear = 0; bus_a.stats_clear = 0;
        bus_b.lookup_pc = '0; bus_b.update_valid = 0; bus_b.update_pc = '0;
        bus_b.update_taken = 0; bus_b.update_target = '0; bus_b.update_mispredict = 0;
        bus_b.table_clear = 0; bus_b.stats_clear = 0;
        #1 nReset = 1'b0;
        tick(); tick();

        // Reset state.
        bus_a.lookup_pc = 32'h100;
        #1;
        check("rst_taken", 32'(bus_a.predict_taken), 0);
        check("rst_hit", 32'(bus_a.predict_hit), 0);
        check("rst_target", bus_a.predict_target, 0);
        check("rst_bcount", 32'(bus_a.branch_count), 0);
        check("rst_mcount", 32'(bus_a.mispredict_count), 0);
        nReset = 1'b1;
        tick();

        // Two taken updates: 01 -> 11.
        upd_a(32'h100, 1, 32'h200, 0);
        upd_a(32'h100, 1, 32'h200, 0);
        check("tk2_taken", 32'(bus_a.predict_taken), 1);
        check("tk2_hit", 32'(bus_a.predict_hit), 1);
        check("tk2_target", bus_a.predict_target, 32'h200);
        check("tk2_bcount", 32'(bus_a.branch_count), 2);

        // Not-taken down to 00, then one more stays at 00.
        upd_a(32'h100, 0, 32'h0, 1);
        check("nt1_taken", 32'(bus_a.predict_taken), 1);
        upd_a(32'h100, 0, 32'h0, 0);
        upd_a(32'h100, 0, 32'h0, 0);
        check("nt3_taken", 32'(bus_a.predict_taken), 0);
        upd_a(32'h100, 0, 32'h0, 0);
        check("nt4_taken", 32'(bus_a.predict_taken), 0);
        check("nt4_hit", 32'(bus_a.predict_hit), 1);
        check("nt4_target", bus_a.predict_target, 32'h200);
        check("nt4_mcount", 32'(bus_a.mispredict_count), 1);

        // update_valid=0 with X payload changes nothing.
        bus_a.update_pc = 'x; bus_a.update_taken = 1'bx;
        bus_a.update_target = 'x; bus_a.update_mispredict = 1'bx;
        tick();
        check("idle_bcount", 32'(bus_a.branch_count), 6);
        check("idle_mcount", 32'(bus_a.mispredict_count), 1);
        check("idle_taken", 32'(bus_a.predict_taken), 0);
        check("idle_target", bus_a.predict_target, 32'h200);

        // 00 -> 01, then a same-cycle update/lookup sees the old entry.
        upd_a(32'h100, 1, 32'h200, 0);
        check("up1_taken", 32'(bus_a.predict_taken), 0);
        bus_a.update_valid = 1; bus_a.update_pc = 32'h100; bus_a.update_taken = 1;
        bus_a.update_target = 32'h204; bus_a.update_mispredict = 0;
        #1;
        check("same_old_taken", 32'(bus_a.predict_taken), 0);
        check("same_old_target", bus_a.predict_target, 32'h200);
        tick();
        bus_a.update_valid = 0;
        check("same_new_taken", 32'(bus_a.predict_taken), 1);
        check("same_new_target", bus_a.predict_target, 32'h204);
        check("same_bcount", 32'(bus_a.branch_count), 8);

        // table_clear beats a concurrent update; statistics still count it.
        bus_a.table_clear = 1;
        upd_a(32'h100, 1, 32'h300, 0);
        bus_a.table_clear = 0;
        check("clr_taken", 32'(bus_a.predict_taken), 0);
        check("clr_hit", 32'(bus_a.predict_hit), 0);
        check("clr_target", bus_a.predict_target, 0);
        check("clr_bcount", 32'(bus_a.branch_count), 9);
        // Counter must be back at 01: one not-taken reaches 00; target stays invalid.
        upd_a(32'h100, 0, 32'h500, 0);
        check("clr_nt_taken", 32'(bus_a.predict_taken), 0);
        check("clr_nt_hit", 32'(bus_a.predict_hit), 0);

        // Aliasing: 0x200 shares index 0 with 0x100 but has a different tag.
        upd_a(32'h100, 1, 32'h444, 0);
        upd_a(32'h100, 1, 32'h444, 0);
        bus_a.lookup_pc = 32'h200;
        #1;
        check("alias_taken", 32'(bus_a.predict_taken), 1);
        check("alias_hit", 32'(bus_a.predict_hit), 0);
        check("alias_target", bus_a.predict_target, 0);
        bus_a.lookup_pc = 32'h100;
        #1;
        check("own_hit", 32'(bus_a.predict_hit), 1);
        check("own_target", bus_a.predict_target, 32'h444);

        // Upper saturation: 10 -> 11 -> 11, then not-taken gives 10.
        upd_a(32'h100, 1, 32'h444, 0);
        upd_a(32'h100, 1, 32'h444, 0);
        upd_a(32'h100, 0, 32'h0, 0);
        check("sat_hi_taken", 32'(bus_a.predict_taken), 1);
        check("b15_bcount", 32'(bus_a.branch_count), 15);
        upd_a(32'h100, 0, 32'h0, 0);
        check("bsat_bcount", 32'(bus_a.branch_count), 15);

        // Mispredict counter saturation.
        bus_a.stats_clear = 1;
        tick();
        bus_a.stats_clear = 0;
        check("sclr_bcount", 32'(bus_a.branch_count), 0);
        check("sclr_mcount", 32'(bus_a.mispredict_count), 0);
        for (int i = 0; i < 16; i++) begin
            upd_a(32'h10, 1, 32'h80, 1);
            if (i == 13) check("m14_mcount", 32'(bus_a.mispredict_count), 14);
        end
        check("msat_mcount", 32'(bus_a.mispredict_count), 15);
        check("msat_bcount", 32'(bus_a.branch_count), 15);

        // stats_clear with an update: stats zero, table still updated.
        bus_a.stats_clear = 1;
        upd_a(32'h20, 1, 32'h99, 1);
        bus_a.stats_clear = 0;
        bus_a.lookup_pc = 32'h20;
        #1;
        check("scu_bcount", 32'(bus_a.branch_count), 0);
        check("scu_mcount", 32'(bus_a.mispredict_count), 0);
        check("scu_taken", 32'(bus_a.predict_taken), 1);
        check("scu_target", bus_a.predict_target, 32'h99);
        upd_a(32'h20, 0, 32'h0, 0);
        check("nomisp_bcount", 32'(bus_a.branch_count), 1);
        check("nomisp_mcount", 32'(bus_a.mispredict_count), 0);

        // Asynchronous reset between clock edges.
        bus_a.lookup_pc = 32'h10;
        #1;
        check("pre_rst_hit", 32'(bus_a.predict_hit), 1);
        nReset = 1'b0;
        #1;
        check("arst_taken", 32'(bus_a.predict_taken), 0);
        check("arst_hit", 32'(bus_a.predict_hit), 0);
        check("arst_target", bus_a.predict_target, 0);
        check("arst_bcount", 32'(bus_a.branch_count), 0);
        nReset = 1'b1;
        tick();

        // Two-entry table with 1-bit counters: counter is the last outcome.
        bus_b.lookup_pc = 32'h4;
        #1;
        check("b_rst_taken", 32'(bus_b.predict_taken), 0);
        upd_b(32'h4, 1, 32'h40);
        check("b_tk_taken", 32'(bus_b.predict_taken), 1);
        check("b_tk_target", bus_b.predict_target, 32'h40);
        bus_b.lookup_pc = 32'h0;
        #1;
        check("b_other_taken", 32'(bus_b.predict_taken), 0);
        check("b_other_hit", 32'(bus_b.predict_hit), 0);
        bus_b.lookup_pc = 32'h4;
        upd_b(32'h4, 0, 32'h0);
        check("b_nt_taken", 32'(bus_b.predict_taken), 0);
        check("b_nt_hit", 32'(bus_b.predict_hit), 1);
        check("b_bcount", 32'(bus_b.branch_count), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
